// File: rtl/stat_display.sv
// Scans one selected 32-bit statistics counter onto an 8-digit common-anode hex display.
// Optional leading-zero blanking is enabled by defining STAT_DISPLAY_BLANK_EN.
module stat_display #(
    parameter int SCAN_DIV = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] SyscallOut,
    input  logic        halt,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [SCAN_DIV-1:0] DIV_MAX = {SCAN_DIV{1'b1}};
    localparam logic [SCAN_DIV-1:0] DIV_ONE = SCAN_DIV'(1);

    logic [SCAN_DIV-1:0] div_q, div_d;
    logic [2:0]          idx_q, idx_d;
    logic [31:0]         shown_q, shown_d;
    logic [7:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                term_cnt, frame_end;
    logic [31:0]         sel_val;
    logic [31:0]         shifted;

    function automatic logic [6:0] hexseg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef STAT_DISPLAY_BLANK_EN
    logic [2:0] msd_q, msd_d;

    // Index of the most significant nonzero nibble; 0 for a zero value.
    function automatic logic [2:0] msd_of(input logic [31:0] v);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) m = 3'(i);
        end
        return m;
    endfunction
`endif

    always_comb begin
        term_cnt  = (div_q == DIV_MAX);
        frame_end = term_cnt && (idx_q == 3'd7);
        div_d     = div_q + DIV_ONE;
        idx_d     = term_cnt ? idx_q + 3'd1 : idx_q;

        case (sel)
            3'd0:    sel_val = total_cycles;
            3'd1:    sel_val = uncondi_num;
            3'd2:    sel_val = condi_num;
            3'd3:    sel_val = condi_suc_num;
            3'd4:    sel_val = SyscallOut;
            default: sel_val = 32'h0;
        endcase

        // Snapshot only at the frame boundary so a frame never mixes two values.
        shown_d = frame_end ? sel_val : shown_q;
        shifted = shown_q >> {idx_q, 2'b00};

        an_d  = ~(8'b1 << idx_q);
        seg_d = hexseg(shifted[3:0]);
        dp_d  = ~(halt && (idx_q == 3'd0));

`ifdef STAT_DISPLAY_BLANK_EN
        msd_d = frame_end ? msd_of(sel_val) : msd_q;
        if (idx_q > msd_q) seg_d = 7'h7F;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            idx_q   <= 3'd0;
            shown_q <= 32'h0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
`ifdef STAT_DISPLAY_BLANK_EN
            msd_q   <= 3'd0;
`endif
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
`ifdef STAT_DISPLAY_BLANK_EN
            msd_q   <= msd_d;
`endif
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
